index_gen: RTL
==============

INDEX_GEN -- requirements
Module: index_gen

Interface
- REQ-001: Parameter REV_300_CYC, default 2000000, clock cycles per revolution at 300 rpm (10 MHz clk).
- REQ-002: Parameter REV_360_CYC, default 1666667, clock cycles per revolution at 360 rpm.
- REQ-003: Parameter PULSE_CYC, default 40000, index pulse width in cycles (4 ms).
- REQ-004: Parameter SPINUP_REVS, default 2, full revolutions before the spindle is declared up to speed.
- REQ-005: clk  input  1  system clock, 10 MHz.
- REQ-006: rst  input  1  reset, asynchronous, active-high.
- REQ-007: spin_en  input  1  spindle motor enable from ctrl_circ, 1 = on.
- REQ-008: spin_ss  input  1  spindle speed select, 1 = 360 rpm, 0 = 300 rpm.
- REQ-009: dsk_sens  input  1  disk present, 1 = present.
- REQ-010: ind_sens  output  1  emulated index sensor to ctrl_circ, active-low, 1 = no hole.
- REQ-011: spin_ready  output  1  spindle at speed, 1 = ready.

Function
- REQ-012: The block SHALL implement states IDLE, SPINUP and RUN.
- REQ-013: The block SHALL hold a 21-bit phase counter and a period register (REV_300_CYC or REV_360_CYC).
- REQ-014: IDLE: phase = 0, ind_sens = 1, spin_ready = 0; go to SPINUP when spin_en = 1 and dsk_sens = 1 on a clock edge.
- REQ-015: On entering SPINUP, the period register SHALL load from spin_ss and phase SHALL start at 0.
- REQ-016: The phase counter SHALL increment every cycle in SPINUP and RUN, wrapping from period-1 to 0.
- REQ-017: At each wrap, the period register SHALL reload from the current spin_ss; a mid-revolution speed change takes effect only at the next wrap.
- REQ-018: SPINUP: ind_sens = 1; after SPINUP_REVS wraps, go to RUN on the wrap edge.
- REQ-019: RUN: spin_ready = 1; ind_sens = 0 while phase < PULSE_CYC, else 1.
- REQ-020: First RUN cycle: phase = 0, so ind_sens is low in that cycle.
- REQ-021: ind_sens and spin_ready SHALL be registered outputs with no combinational path from inputs.
- REQ-022: spin_en = 0 or dsk_sens = 0 in any state: next state IDLE; ind_sens = 1 and spin_ready = 0 on the following cycle; any in-progress pulse is truncated.
- REQ-023: Re-enable after a drop SHALL restart a full SPINUP; no prior progress is retained.
- REQ-024: If PULSE_CYC >= period, ind_sens SHALL stay low continuously in RUN. Parameter legality is not checked.

Reset
- REQ-025: rst = 1 SHALL immediately force IDLE, phase = 0, revolution count = 0, ind_sens = 1, spin_ready = 0, regardless of clk.
- REQ-026: Reset mid-pulse SHALL release ind_sens to 1 asynchronously.
- REQ-027: After rst deassertion, operation SHALL resume from IDLE on the next clock edge.

Configuration
- REQ-028: Macro INDEX_GEN_REV_COUNT_EN, when defined, SHALL add output rev_cnt (16 bits).
- REQ-029: rev_cnt SHALL increment on each wrap in RUN, wrap from 0xFFFF to 0, and clear in IDLE and on reset.
- REQ-030: Without INDEX_GEN_REV_COUNT_EN, rev_cnt SHALL be absent and all other behaviour identical.

Verification (bench parameters: REV_300_CYC=100, REV_360_CYC=80, PULSE_CYC=10, SPINUP_REVS=2)
- REQ-031: Spin-up at 300 rpm: spin_en=1, dsk_sens=1, spin_ss=0 -> spin_ready rises 200 cycles after IDLE exit; then ind_sens low 10 cycles, high 90, period 100.
- REQ-032: Speed change: spin_ss 0->1 at phase 50 in RUN -> current revolution completes at 100 cycles; following pulses repeat every 80 cycles; spin_ready stays 1.
- REQ-033: Disk removal: dsk_sens=0 at phase 5 of a pulse -> ind_sens=1 and spin_ready=0 one cycle later; no further pulses.
- REQ-034: Async reset: rst=1 asserted between clk edges mid-pulse -> ind_sens=1 immediately; re-enable -> full 200-cycle spin-up again.
- REQ-035: Motor off: spin_en=0 at power-up with dsk_sens=1 for 1000 cycles -> ind_sens constant 1, spin_ready constant 0.
- REQ-036: With INDEX_GEN_REV_COUNT_EN defined: after 5 RUN revolutions -> rev_cnt=5; after spin_en=0 -> rev_cnt=0.

Source files
------------

// File: rtl/index_gen.sv
// ---------------------------------------------------------------------------
// index_gen -- floppy spindle / index-hole emulator
//
// Emulates a spinning disk for the controller: once the motor is enabled
// with a disk present, a phase counter sweeps one revolution at a time.
// After SPINUP_REVS revolutions the spindle is reported ready and an
// active-low index pulse is produced at the start of every revolution.
//
// Parameters
//   REV_300_CYC  clock cycles per revolution at 300 rpm
//   REV_360_CYC  clock cycles per revolution at 360 rpm
//   PULSE_CYC    index pulse width in cycles
//   SPINUP_REVS  revolutions before spin_ready is asserted
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   spin_en     spindle motor enable, 1 = on
//   spin_ss     speed select, 1 = 360 rpm, 0 = 300 rpm
//   dsk_sens    disk present, 1 = present
//   ind_sens    emulated index sensor, active-low (registered)
//   spin_ready  spindle at speed (registered)
//   rev_cnt     16-bit count of revolutions completed in RUN
//               (only when INDEX_GEN_REV_COUNT_EN is defined)
//
// Configuration macro: INDEX_GEN_REV_COUNT_EN
// ---------------------------------------------------------------------------
module index_gen #(
    parameter int REV_300_CYC = 2000000,
    parameter int REV_360_CYC = 1666667,
    parameter int PULSE_CYC   = 40000,
    parameter int SPINUP_REVS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spin_en,
    input  logic        spin_ss,
    input  logic        dsk_sens,
    output logic        ind_sens,
    output logic        spin_ready
`ifdef INDEX_GEN_REV_COUNT_EN
    ,
    output logic [15:0] rev_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPINUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [20:0] PER_300   = 21'(REV_300_CYC);
    localparam logic [20:0] PER_360   = 21'(REV_360_CYC);
    localparam logic [31:0] PULSE_LEN = 32'(PULSE_CYC);
    // Spin-up revolution count at which the wrap edge moves us into RUN.
    localparam logic [15:0] LAST_REV  = 16'(SPINUP_REVS - 1);

    state_t      state;
    logic [20:0] phase;
    logic [20:0] period;
    logic [15:0] revs;

    logic        go;
    logic        wrap;
    logic [20:0] phase_inc;
    logic [20:0] period_sel;

    assign go         = spin_en & dsk_sens;
    assign wrap       = (phase == period - 21'd1);
    assign phase_inc  = phase + 21'd1;
    // The speed select is only sampled when a revolution starts, so a
    // change mid-revolution lands on the next wrap.
    assign period_sel = spin_ss ? PER_360 : PER_300;

    // Index hole is under the sensor for the first PULSE_CYC cycles of each
    // revolution. Widened compare so PULSE_CYC >= period simply keeps the
    // pulse asserted for the whole revolution.
    function automatic logic in_pulse(input logic [20:0] p);
        return ({11'd0, p} < PULSE_LEN);
    endfunction

    // Outputs are computed from the next-cycle phase/state so they line up
    // with the registered phase without any combinational path to inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 21'd0;
            period     <= PER_300;
            revs       <= 16'd0;
            ind_sens   <= 1'b1;
            spin_ready <= 1'b0;
`ifdef INDEX_GEN_REV_COUNT_EN
            rev_cnt    <= 16'd0;
`endif
        end else if (!go) begin
            // Motor off or disk pulled: abort whatever was in progress,
            // including truncating a pulse, and forget spin-up progress.
            state      <= IDLE;
            phase      <= 21'd0;
            revs       <= 16'd0;
            ind_sens   <= 1'b1;
            spin_ready <= 1'b0;
`ifdef INDEX_GEN_REV_COUNT_EN
            rev_cnt    <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state      <= SPINUP;
                    phase      <= 21'd0;
                    period     <= period_sel;
                    revs       <= 16'd0;
                    ind_sens   <= 1'b1;
                    spin_ready <= 1'b0;
`ifdef INDEX_GEN_REV_COUNT_EN
                    rev_cnt    <= 16'd0;
`endif
                end

                SPINUP: begin
                    if (wrap) begin
                        phase  <= 21'd0;
                        period <= period_sel;
                        if (revs == LAST_REV) begin
                            // First RUN cycle sits at phase 0, so the pulse
                            // starts right away.
                            state      <= RUN;
                            spin_ready <= 1'b1;
                            ind_sens   <= ~in_pulse(21'd0);
                        end else begin
                            revs     <= revs + 16'd1;
                            ind_sens <= 1'b1;
                        end
                    end else begin
                        phase    <= phase_inc;
                        ind_sens <= 1'b1;
                    end
                end

                RUN: begin
                    spin_ready <= 1'b1;
                    if (wrap) begin
                        phase    <= 21'd0;
                        period   <= period_sel;
                        ind_sens <= ~in_pulse(21'd0);
`ifdef INDEX_GEN_REV_COUNT_EN
                        rev_cnt  <= rev_cnt + 16'd1;
`endif
                    end else begin
                        phase    <= phase_inc;
                        ind_sens <= ~in_pulse(phase_inc);
                    end
                end

                default: begin
                    state      <= IDLE;
                    phase      <= 21'd0;
                    revs       <= 16'd0;
                    ind_sens   <= 1'b1;
                    spin_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
